// File: rtl/right_shift_deser.sv
// Serial-to-parallel receiver with a one-deep valid/ready holding register.
// Build option RSD_MSB_FIRST_EN: bits arrive MSB first (left-shift link); default is LSB first.
module right_shift_deser #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          align,
  input  logic          din_en,
  input  logic          din,
  input  logic          dout_rdy,
  input  logic          ovf_clr,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          busy,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] sr_reg, sr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] dout_reg, dout_next;
  logic          dout_vld_reg, dout_vld_next;
  logic          busy_reg;
  logic          ovf_reg, ovf_next;
  logic [DW-1:0] word;
  logic          shift, complete, accept, drop;

  always_comb begin
    shift    = din_en & ~align;
    complete = shift && (cnt_reg == CW'(DW - 1));
    accept   = dout_vld_reg & dout_rdy;
`ifdef RSD_MSB_FIRST_EN
    word     = {sr_reg[DW-2:0], din};
`else
    word     = {din, sr_reg[DW-1:1]};
`endif

    sr_next  = sr_reg;
    cnt_next = cnt_reg;
    if (align) begin
      sr_next  = '0;
      cnt_next = '0;
    end else if (din_en) begin
      sr_next  = word;
      cnt_next = complete ? '0 : cnt_reg + CW'(1);
    end

    // A finished word lands only if the holding register is free or draining this cycle.
    dout_next     = dout_reg;
    dout_vld_next = dout_vld_reg;
    drop          = 1'b0;
    if (complete) begin
      if (!dout_vld_reg || accept) begin
        dout_next     = word;
        dout_vld_next = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (accept) begin
      dout_vld_next = 1'b0;
    end

    ovf_next = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sr_reg       <= '0;
      cnt_reg      <= '0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      sr_reg       <= sr_next;
      cnt_reg      <= cnt_next;
      dout_reg     <= dout_next;
      dout_vld_reg <= dout_vld_next;
      busy_reg     <= (cnt_next != '0);
      ovf_reg      <= ovf_next;
    end
  end

  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;
  assign busy     = busy_reg;
  assign ovf      = ovf_reg;

endmodule
